// File: rtl/boot_loader_ctrl.sv
// Boot-time loader: assembles a byte stream into 32-bit words, programs instruction memory,
// verifies a trailing XOR checksum and then releases the core to run from address 0.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// HDR   | receiving the 4-byte program length
// LOAD  | receiving a program word
// WR    | one-cycle memory write of the assembled word
// CHK   | receiving the checksum word
// BOOT  | holding core reset for BOOT_CYC cycles after a good load
// RUN   | core released and running
// ERR   | bad length or checksum, core held in reset
module boot_loader_ctrl #(
    parameter int unsigned MAX_WORDS = 65536,
    parameter int unsigned BOOT_CYC  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog,
    output logic        write,
    output logic [31:0] addr,
    output logic [31:0] data_o,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;

    // Upper 7 bits of each encoding are the outputs themselves, so every status
    // output comes straight from a flop: {rx_ready, prog, write, core_reset, busy, done, err, tag[1:0]}.
    typedef enum logic [8:0] {
        S_IDLE = 9'b000100000,
        S_HDR  = 9'b110110000,
        S_LOAD = 9'b110110001,
        S_CHK  = 9'b110110010,
        S_WR   = 9'b011110000,
        S_BOOT = 9'b000110000,
        S_RUN  = 9'b000001000,
        S_ERR  = 9'b000100100
    } state_t;

    state_t         state;
    logic [1:0]     byte_cnt;
    logic [23:0]    byte_sr;
    logic [31:0]    len;
    logic [31:0]    word_cnt;
    logic [31:0]    csum;
    logic [BW-1:0]  boot_cnt;

    logic           take;
    logic           word_end;
    logic [31:0]    word;

    assign rx_ready   = state[8];
    assign prog       = state[7];
    assign write      = state[6];
    assign core_reset = state[5];
    assign busy       = state[4];
    assign done       = state[3];
    assign err        = state[2];

    assign take     = rx_valid && rx_ready;
    assign word_end = take && (byte_cnt == 2'd3);
    assign word     = {byte_sr, rx_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr     <= '0;
            data_o   <= '0;
            byte_cnt <= '0;
            byte_sr  <= '0;
            len      <= '0;
            word_cnt <= '0;
            csum     <= '0;
            boot_cnt <= '0;
        end else begin
            // Partial words survive stalls; the counter wraps on its own after byte 4.
            if (take) begin
                byte_sr  <= {byte_sr[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        csum     <= '0;
                    end
                end
                S_HDR: begin
                    if (word_end) begin
                        if (word == 32'd0 || word > MAX_WORDS) begin
                            state <= S_ERR;
                        end else begin
                            len   <= word;
                            addr  <= '0;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (word_end) begin
                        data_o <= word;
                        csum   <= csum ^ word;
                        state  <= S_WR;
                    end
                end
                S_WR: begin
                    addr     <= addr + 32'd1;
                    word_cnt <= word_cnt + 32'd1;
                    state    <= (word_cnt + 32'd1 == len) ? S_CHK : S_LOAD;
                end
                S_CHK: begin
                    if (word_end) begin
                        state    <= (word == csum) ? S_BOOT : S_ERR;
                        boot_cnt <= BW'(BOOT_CYC - 1);
                    end
                end
                S_BOOT: begin
                    if (boot_cnt == '0) state <= S_RUN;
                    else                boot_cnt <= boot_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: directed and random byte streams checked
// against a stream-level model of the expected memory writes and final outcome.
module tb_boot_loader_ctrl;

    localparam int unsigned MAXW = 65536;
    localparam int unsigned BOOT = 4;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, prog, write, core_reset, busy, done, err;
    logic [31:0] addr, data_o;

    boot_loader_ctrl #(.MAX_WORDS(MAXW), .BOOT_CYC(BOOT)) dut (
        .clk(clk), .reset(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .prog(prog), .write(write), .addr(addr), .data_o(data_o),
        .core_reset(core_reset), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0]  stream[$];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    int boot_seen, viol_rdy, viol_prog;

    // Observe the memory interface away from the rising edge.
    always @(negedge clk) begin
        if (write) begin
            got_addr.push_back(addr);
            got_data.push_back(data_o);
            if (rx_ready) viol_rdy++;
            if (!prog) viol_prog++;
        end
        if (busy && !prog) boot_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int k);
        return {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) stream.push_back(8'(w >> (8*i)));
    endtask

    task automatic build(input int unsigned n, input bit corrupt);
        logic [31:0] x = 0;
        logic [31:0] w;
        stream.delete();
        push_word(n);
        for (int i = 0; i < int'(n); i++) begin
            w = $urandom;
            x ^= w;
            push_word(w);
        end
        if (corrupt) x ^= (32'd1 << $urandom_range(0, 31));
        push_word(x);
    endtask

    // Expected writes and outcome, straight from the stream contents.
    task automatic model(output bit ok, output logic [31:0] n);
        logic [31:0] x = 0;
        exp_addr.delete();
        exp_data.delete();
        n = wd(0);
        ok = 1'b0;
        if (n == 0 || n > MAXW) return;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(wd(i + 1));
            x ^= wd(i + 1);
        end
        ok = (wd(int'(n) + 1) == x);
    endtask

    task automatic send(input int n, input int vprob, input int stall_at, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit stalled = 0, pulsed = 0, tk;
        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (idx == stall_at && !stalled) begin
                stalled = 1;
                rx_valid = 1'b0;
                repeat (10) @(negedge clk);
            end
            if (idx == start_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end
            rx_valid = ($urandom_range(0, 99) < vprob);
            rx_data = stream[idx];
            tk = rx_valid && rx_ready;
            @(posedge clk);
            if (tk) idx++;
        end
        start = 1'b0;
        chk("bytes_accepted", idx, n);
    endtask

    task automatic run(input string tag, input bit do_start, input int vprob, input int stall_at,
                       input int start_at, input bit pulse_boot);
        bit ok, p;
        logic [31:0] n;
        int cyc;
        model(ok, n);
        got_addr.delete();
        got_data.delete();
        boot_seen = 0; viol_rdy = 0; viol_prog = 0;
        if (do_start) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        send(stream.size(), vprob, stall_at, start_at);
        cyc = 0; p = 0;
        while (cyc < 60) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start = 1'b0;
            if (done || err) break;
            if (pulse_boot && busy && !prog && !p) begin
                start = 1'b1;
                p = 1;
            end
            cyc++;
        end
        chk({tag, "_finished"}, done | err, 1'b1);
        chk({tag, "_done"}, done, ok);
        chk({tag, "_err"}, err, !ok);
        chk({tag, "_core_reset"}, core_reset, !ok);
        chk({tag, "_prog"}, prog, 1'b0);
        chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) begin
                chk({tag, "_waddr"}, got_addr[i], exp_addr[i]);
                chk({tag, "_wdata"}, got_data[i], exp_data[i]);
            end
        end
        if (ok) begin
            chk({tag, "_final_addr"}, addr, n);
            chk({tag, "_boot_cycles"}, boot_seen, BOOT);
        end
        chk({tag, "_ready_in_write"}, viol_rdy, 0);
        chk({tag, "_write_wo_prog"}, viol_prog, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_prog"}, prog, 1'b0);
        chk({tag, "_write"}, write, 1'b0);
        chk({tag, "_addr"}, addr, 32'd0);
        chk({tag, "_data"}, data_o, 32'd0);
        chk({tag, "_core_reset"}, core_reset, 1'b1);
        chk({tag, "_rx_ready"}, rx_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed normal load with ignored starts in LOAD and BOOT.
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                   8'h20, 8'h02, 8'h00, 8'h03, 8'h00, 8'h03, 8'h00, 8'h06};
        run("normal", 1, 100, -1, 9, 1);
        if (got_data.size() == 2) begin
            chk("normal_word0", got_data[0], 32'h20010005);
            chk("normal_word1", got_data[1], 32'h20020003);
        end

        // start in RUN re-enters the header phase on the next cycle.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("restart_core_reset", core_reset, 1'b1);
        chk("restart_prog", prog, 1'b1);
        chk("restart_done", done, 1'b0);

        stream[15] = 8'h07;
        run("badsum", 0, 100, -1, -1, 0);

        stream[15] = 8'h06;
        run("stall", 1, 50, 6, -1, 0);

        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        run("len_zero", 1, 100, -1, -1, 0);
        stream = '{8'h00, 8'h01, 8'h00, 8'h01};
        run("len_big", 1, 100, -1, -1, 0);

        for (int t = 0; t < 6; t++) begin
            build($urandom_range(1, 5), $urandom_range(0, 2) == 0);
            run("rand", 1, $urandom_range(30, 100), (t == 0) ? 7 : -1, -1, 0);
        end

        // Asynchronous reset between edges, after the first data word is written.
        build(3, 0);
        got_addr.delete();
        got_data.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        send(8, 100, -1, -1);
        @(negedge clk) rx_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midload_rst");
        chk("midload_writes", got_addr.size(), 1);
        #1 rst_n = 1'b1;
        run("reload", 1, 100, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Boot-time programming controller for the 8-bit MIPS-style core.
- Receives a byte stream over a valid/ready handshake and assembles bytes into 32-bit instruction words.
- Drives the instruction-memory programming interface (prog, write, addr, data) to load those words.
- Holds the core in reset throughout loading, checks a trailing XOR checksum, then releases the core to run from address 0.

Parameters:
- MAX_WORDS, 65536, largest accepted program length in words; larger headers are an error.
- BOOT_CYC, 4, number of cycles core_reset stays high after a successful load, before release.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, RUN or ERR.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  controller accepts a byte this cycle.
- prog  output  1  program mode to the core's instruction-memory address mux.
- write  output  1  instruction-memory write strobe.
- addr  output  32  instruction-memory word address.
- data_o  output  32  instruction word to write.
- core_reset  output  1  active-high synchronous reset to the core.
- busy  output  1  high in HDR, LOAD, CHK and BOOT.
- done  output  1  high in RUN.
- err  output  1  high in ERR.

Behaviour:
- Byte transfer: a byte is taken only when rx_valid and rx_ready are both high on a rising edge.
- rx_ready is high in HDR, LOAD and CHK. It is low in all other states and low in the cycle write is high.
- Word assembly: bytes are big-endian (first byte goes to [31:24]). A 2-bit byte counter wraps after 4 bytes and marks word complete.
- Reset (reset=0, takes effect immediately):
  - state=IDLE, prog=0, write=0, addr=0, data_o=0.
  - core_reset=1, rx_ready=0, busy=0, done=0, err=0.
  - Byte counter, word counter and checksum cleared.
- IDLE: core_reset=1. On start go to HDR and clear the counters and the checksum.
- HDR:
  - prog=1, core_reset=1.
  - Assemble one word as the length L.
  - L=0 or L>MAX_WORDS: go to ERR.
  - Otherwise latch L, set addr=0, go to LOAD.
  - The header is not included in the checksum.
- LOAD:
  - prog=1.
  - When the 4th byte of a word is accepted, the next cycle has data_o=word and write=1 for exactly 1 cycle, at the current addr. The checksum XORs in the word.
  - The cycle after the write, addr increments by 1.
  - After word L is written, go to CHK. addr stays at L; no wrap.
- CHK:
  - prog=1.
  - Assemble one word. If it equals the running XOR of all L data words, go to BOOT; otherwise go to ERR.
- BOOT: prog=0, core_reset=1 for BOOT_CYC cycles, then go to RUN.
- RUN: prog=0, core_reset=0, done=1. start goes back to HDR and asserts core_reset in the next cycle.
- ERR: prog=0, core_reset=1, err=1. Held until start (goes to HDR) or reset.
- start in HDR, LOAD, CHK or BOOT is ignored.
- Stalls: rx_valid low at any point simply stalls. There is no timeout, and partial bytes are retained.
- Memory consistency: write is never high while prog=0. addr and data_o are stable in every cycle write=1.
- Reset mid-load: the partial program stays in memory but the core stays reset. Nothing else is preserved.

Test Plan:
- Normal load: start, then bytes 00 00 00 02 | 20 01 00 05 | 20 02 00 03 | 00 03 00 06 -> two write pulses (addr 0 data 0x20010005, addr 1 data 0x20020003). Checksum 0x00030006 matches -> BOOT for 4 cycles, then done=1, core_reset=0, prog=0.
- Bad checksum: same stream with final byte 07 -> err=1, core_reset=1, done=0. Then start plus a valid stream -> done=1.
- Zero length: header 00 00 00 00 -> err=1 with no write pulse. Header 0x00010001 with MAX_WORDS=65536 -> err=1.
- Handshake stall: rx_valid toggled randomly, including low for 10 cycles mid-word -> words are identical to the unstalled case. rx_ready is never high in a write cycle, and no byte is lost or duplicated.
- Asynchronous reset: drop reset mid-LOAD, between clock edges after word 1 -> all outputs return to reset values without waiting for a clock edge. Reload then starts cleanly from addr 0.
- Ignored start: pulse start during LOAD and during BOOT -> no state change. A start in RUN -> core_reset=1 and prog=1 on the next cycle.
